// File: rtl/risc_cpu_param.sv
// risc_cpu_param: parametrised accumulator CPU core with an external single-port memory bus.
//
// ISA (3-bit opcode in word[ADDR_W+2:ADDR_W], operand in word[ADDR_W-1:0]):
//   000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP
// Every instruction is fetched in FETCH and decoded in EXEC.
// ALU/LDA/STO instructions then do one data access in MEMOP.
// HLT parks the core in HALTED until a resume pulse arrives.
// DATA_W must be at least ADDR_W+3 so that a memory word can hold a whole instruction.
//
// Parameters:
//   DATA_W    accumulator and memory word width
//   ADDR_W    address width (PC and operand)
//   RESET_PC  PC value after reset
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   resume     single-cycle pulse, leaves HALTED
//   mem_req    memory access request
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   access address (valid with mem_req)
//   mem_wdata  write data, always the accumulator
//   mem_rdata  read data, sampled on the completing edge
//   mem_ready  access completes on an edge where mem_req and mem_ready are both high
//   halt       high while halted
//   pc, acc    debug views of the program counter and the accumulator
//   zero       acc == 0
//
// Optional feature, enabled by defining RISC_CPU_PERF_EN:
//   cyc_cnt  saturating count of cycles spent outside HALTED
//   ret_cnt  saturating count of retired instructions
module risc_cpu_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero
`ifdef RISC_CPU_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  localparam int unsigned IrW = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {StFetch, StExec, StMemop, StHalted} state_e;
  typedef enum logic [2:0] {
    OpHlt, OpSkz, OpAdd, OpAnd, OpXor, OpLda, OpSto, OpJmp
  } opcode_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  // Only the opcode and operand fields are kept; higher word bits are ignored by the ISA.
  logic [IrW-1:0]    ir_q, ir_d;
  logic              bus_req, bus_we;

  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = opcode_e'(ir_q[IrW-1:ADDR_W]);
  assign operand = ir_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= ResetPc;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    bus_req  = 1'b0;
    bus_we   = 1'b0;
    mem_addr = pc_q;

    unique case (state_q)
      StFetch: begin
        bus_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata[IrW-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (opcode)
          OpHlt: state_d = StHalted;
          OpSkz: begin
            if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
          OpJmp: begin
            pc_d    = operand;
            state_d = StFetch;
          end
          OpAdd, OpAnd, OpXor, OpLda, OpSto: state_d = StMemop;
          default: state_d = StFetch;
        endcase
      end
      StMemop: begin
        bus_req  = 1'b1;
        bus_we   = (opcode == OpSto);
        mem_addr = operand;
        if (mem_ready) begin
          unique case (opcode)
            OpAdd:   acc_d = acc_q + mem_rdata;
            OpAnd:   acc_d = acc_q & mem_rdata;
            OpXor:   acc_d = acc_q ^ mem_rdata;
            OpLda:   acc_d = mem_rdata;
            default: acc_d = acc_q;
          endcase
          state_d = StFetch;
        end
      end
      StHalted: begin
        if (resume) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset is FETCH, so request outputs are gated by rst to drop as soon as reset asserts.
  assign mem_req   = bus_req & rst;
  assign mem_we    = bus_we & rst;
  assign mem_wdata = acc_q;
  assign halt      = (state_q == StHalted);
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign zero      = (acc_q == '0);

`ifdef RISC_CPU_PERF_EN
  logic        ret_inc;
  logic [31:0] cyc_cnt_q, ret_cnt_q;

  assign ret_inc = ((state_q == StExec) &&
                    (opcode == OpHlt || opcode == OpSkz || opcode == OpJmp)) ||
                   ((state_q == StMemop) && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (state_q != StHalted && cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (ret_inc && ret_cnt_q != '1) ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_risc_cpu_param.sv
// Bench for risc_cpu_param: a default 8/5 core drives a scoreboarded memory model with configurable
// wait states; a 16/8 core checks PC wrap and wide XOR.
module tb_risc_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width core
  logic       rst, resume;
  logic       mem_req, mem_we, mem_ready, halt, zero;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata, acc;

  // Wide core
  logic        rst_b;
  logic        b_mem_req, b_mem_we, b_mem_ready, b_halt, b_zero;
  logic [7:0]  b_mem_addr, b_pc;
  logic [15:0] b_mem_wdata, b_mem_rdata, b_acc;

`ifdef RISC_CPU_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt, b_cyc_cnt, b_ret_cnt;
`endif

  risc_cpu_param dut (
    .clk(clk), .rst(rst), .resume(resume),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halt(halt), .pc(pc), .acc(acc), .zero(zero)
`ifdef RISC_CPU_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  risc_cpu_param #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0)) dut_b (
    .clk(clk), .rst(rst_b), .resume(1'b0),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .halt(b_halt), .pc(b_pc), .acc(b_acc), .zero(b_zero)
`ifdef RISC_CPU_PERF_EN
    , .cyc_cnt(b_cyc_cnt), .ret_cnt(b_ret_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endfunction

  // Memory model for the default core
  logic [7:0] mem [32];
  int         wait_cfg = 0;
  int         wait_cnt;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (wait_cnt >= wait_cfg);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_cnt <= 0;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Memory model for the wide core (zero wait)
  logic [15:0] mem_b [256];
  assign b_mem_rdata = mem_b[b_mem_addr];
  assign b_mem_ready = 1'b1;

  always @(posedge clk) begin
    if (rst_b && b_mem_req && b_mem_we) mem_b[b_mem_addr] = b_mem_wdata;
  end

  // Scoreboard: each completed access is matched against the next expected transfer
  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } xfer_t;
  xfer_t exp_q[$];

  always @(negedge clk) begin
    xfer_t e;
    if (rst && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_access: got addr 0x%0h we %0b, required no access",
                 mem_addr, mem_we);
      end else begin
        e = exp_q.pop_front();
        check("xfer_addr", 32'(mem_addr), 32'(e.addr));
        check("xfer_we", 32'(mem_we), 32'(e.we));
        if (e.we) check("xfer_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
    end
  end

  // Request attributes must hold while a request waits
  logic       hold_v = 1'b0;
  logic       hold_we;
  logic [4:0] hold_addr;
  logic [7:0] hold_wdata;

  always @(negedge clk) begin
    if (rst && hold_v && mem_req) begin
      check("hold_addr", 32'(mem_addr), 32'(hold_addr));
      check("hold_we", 32'(mem_we), 32'(hold_we));
      if (hold_we) check("hold_wdata", 32'(mem_wdata), 32'(hold_wdata));
    end
    hold_v     <= rst && mem_req && !mem_ready;
    hold_we    <= mem_we;
    hold_addr  <= mem_addr;
    hold_wdata <= mem_wdata;
  end

  task automatic push(input logic we, input logic [4:0] addr, input logic [7:0] wdata);
    exp_q.push_back({we, addr, wdata});
  endtask

  task automatic push_basic_prog();
    push(1'b0, 5'h00, 8'h00);
    push(1'b0, 5'h10, 8'h00);
    push(1'b0, 5'h01, 8'h00);
    push(1'b0, 5'h11, 8'h00);
    push(1'b0, 5'h02, 8'h00);
    push(1'b1, 5'h12, 8'h01);
    push(1'b0, 5'h03, 8'h00);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_basic_prog();
    mem[0]     = 8'hB0;  // LDA 0x10
    mem[1]     = 8'h51;  // ADD 0x11
    mem[2]     = 8'hD2;  // STO 0x12
    mem[3]     = 8'h00;  // HLT
    mem[5'h10] = 8'h05;
    mem[5'h11] = 8'hFC;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int i = 0;
    while (!halt && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, 32'(halt), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    rst_b  = 1'b0;
    resume = 1'b0;

    // Reset state and zero-wait basic program
    enter_reset();
    load_basic_prog();
    #3;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_zero", 32'(zero), 32'h1);
    push_basic_prog();
    release_reset();
    repeat (10) @(posedge clk);
    #1 check("halt_cyc10", 32'(halt), 32'h0);
    @(posedge clk);
    #1 check("halt_cyc11", 32'(halt), 32'h1);
    check("basic_pc", 32'(pc), 32'h04);
    check("basic_acc", 32'(acc), 32'h01);
    check("basic_mem12", 32'(mem[5'h12]), 32'h01);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Same program with three wait states per access
    enter_reset();
    load_basic_prog();
    wait_cfg = 3;
    push_basic_prog();
    release_reset();
    wait_halt("wait_halt", 200);
    check("wait_pc", 32'(pc), 32'h04);
    check("wait_acc", 32'(acc), 32'h01);
    check("wait_mem12", 32'(mem[5'h12]), 32'h01);
    check("wait_q_empty", 32'(exp_q.size()), 32'd0);

    // SKZ at pc=2 with acc=0 skips to 4
    enter_reset();
    wait_cfg = 0;
    mem[0] = 8'hE2;  // JMP 2
    mem[2] = 8'h20;  // SKZ
    mem[3] = 8'h00;
    mem[4] = 8'h00;
    push(1'b0, 5'h00, 8'h00);
    push(1'b0, 5'h02, 8'h00);
    push(1'b0, 5'h04, 8'h00);
    release_reset();
    wait_halt("skz0_halt", 50);
    check("skz0_pc", 32'(pc), 32'h05);
    check("skz0_q_empty", 32'(exp_q.size()), 32'd0);

    // SKZ at pc=2 with acc=1 falls through to 3
    enter_reset();
    mem[0]     = 8'hB0;  // LDA 0x10
    mem[1]     = 8'hE2;  // JMP 2
    mem[2]     = 8'h20;  // SKZ
    mem[3]     = 8'h00;
    mem[5'h10] = 8'h01;
    push(1'b0, 5'h00, 8'h00);
    push(1'b0, 5'h10, 8'h00);
    push(1'b0, 5'h01, 8'h00);
    push(1'b0, 5'h02, 8'h00);
    push(1'b0, 5'h03, 8'h00);
    release_reset();
    wait_halt("skz1_halt", 50);
    check("skz1_pc", 32'(pc), 32'h04);
    check("skz1_q_empty", 32'(exp_q.size()), 32'd0);

    // HLT at 0x03, resume while running is ignored, resume while halted restarts at 0x04
    enter_reset();
    mem[0]     = 8'hB0;  // LDA 0x10
    mem[1]     = 8'h91;  // XOR 0x11
    mem[2]     = 8'h72;  // AND 0x12
    mem[3]     = 8'h00;  // HLT
    mem[4]     = 8'hB3;  // LDA 0x13
    mem[5]     = 8'h00;  // HLT
    mem[5'h10] = 8'h07;
    mem[5'h11] = 8'h0F;
    mem[5'h12] = 8'h0C;
    mem[5'h13] = 8'h00;
    push(1'b0, 5'h00, 8'h00);
    push(1'b0, 5'h10, 8'h00);
    push(1'b0, 5'h01, 8'h00);
    push(1'b0, 5'h11, 8'h00);
    push(1'b0, 5'h02, 8'h00);
    push(1'b0, 5'h12, 8'h00);
    push(1'b0, 5'h03, 8'h00);
    release_reset();
    @(posedge clk);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    wait_halt("res_halt1", 50);
    check("res_acc1", 32'(acc), 32'h08);
    check("res_pc1", 32'(pc), 32'h04);
    check("res_q_empty1", 32'(exp_q.size()), 32'd0);
    push(1'b0, 5'h04, 8'h00);
    push(1'b0, 5'h13, 8'h00);
    push(1'b0, 5'h05, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    check("res_still_halt", 32'(halt), 32'h1);
    check("res_halt_noreq", 32'(mem_req), 32'h0);
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk);
    #1;
    check("res_fetch_req", 32'(mem_req), 32'h1);
    check("res_fetch_addr", 32'(mem_addr), 32'h04);
    check("res_fetch_halt", 32'(halt), 32'h0);
    @(negedge clk);
    resume = 1'b0;
    wait_halt("res_halt2", 50);
    check("res_acc2", 32'(acc), 32'h00);
    check("res_zero2", 32'(zero), 32'h1);
    check("res_pc2", 32'(pc), 32'h06);
    check("res_q_empty2", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-MEMOP takes effect before the next edge
    enter_reset();
    wait_cfg = 3;
    mem[0]     = 8'hB0;
    mem[1]     = 8'h51;
    mem[5'h10] = 8'h05;
    mem[5'h11] = 8'hFC;
    push(1'b0, 5'h00, 8'h00);
    push(1'b0, 5'h10, 8'h00);
    push(1'b0, 5'h01, 8'h00);
    release_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 5'h11) break;
    end
    check("mid_reached", 32'(mem_req && mem_addr == 5'h11), 32'h1);
    check("mid_acc_before", 32'(acc), 32'h05);
    #2 rst = 1'b0;
    #1;
    check("mid_req", 32'(mem_req), 32'h0);
    check("mid_pc", 32'(pc), 32'h00);
    check("mid_acc", 32'(acc), 32'h00);
    check("mid_halt", 32'(halt), 32'h0);
    check("mid_q_empty", 32'(exp_q.size()), 32'd0);

    // Wide core: JMP 0xFF, fetch at 0xFF wraps pc, XOR 0xFFFF with acc=0x00FF
    for (int i = 0; i < 256; i++) mem_b[i] = 16'h0000;
    mem_b[8'h00] = 16'h0511;  // LDA 0x11
    mem_b[8'h01] = 16'h07FF;  // JMP 0xFF
    mem_b[8'hFF] = 16'h0410;  // XOR 0x10
    mem_b[8'h10] = 16'hFFFF;
    mem_b[8'h11] = 16'h00FF;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_mem_req && !b_mem_we && b_mem_addr == 8'hFF) break;
    end
    check("wide_reached", 32'(b_mem_req && b_mem_addr == 8'hFF), 32'h1);
    @(posedge clk);
    #1;
    check("wide_pc_wrap", 32'(b_pc), 32'h00);
    check("wide_acc_pre", 32'(b_acc), 32'h00FF);
    check("wide_exec_noreq", 32'(b_mem_req), 32'h0);
    @(posedge clk);
    #1;
    check("wide_memop_req", 32'(b_mem_req), 32'h1);
    check("wide_memop_addr", 32'(b_mem_addr), 32'h10);
    @(posedge clk);
    #1;
    check("wide_xor", 32'(b_acc), 32'hFF00);
    @(negedge clk);
    rst_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
